// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_stream_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam string MSG_OVERFLOW  = "fifo_skid_buf: word captured into a full buffer with no pop";
  localparam string MSG_UNDERFLOW = "fifo_stream_reader: fifo_rd asserted while fifo_empty is high";

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered register buffer; head_data is always the oldest word.
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] tail_data;

  // A pop on an empty buffer is ignored; push+pop at occ==2 shifts tail forward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ       <= '0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= push_data;
            occ       <= occ + 2'd1;
          end else if (occ == 2'd1) begin
            tail_data <= push_data;
            occ       <= occ + 2'd1;
          end
        end
        2'b01: begin
          if (occ != 2'd0) begin
            head_data <= tail_data;
            occ       <= occ - 2'd1;
          end
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_data <= tail_data;
            tail_data <= push_data;
          end else begin
            head_data <= push_data;
            occ       <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  overflow_check: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && occ == occ_t'(BUF_DEPTH)))
    else $error("%s", MSG_OVERFLOW);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the FIFO via fifo_rd/fifo_empty and presents a valid/ready stream.
// Optional transfer counter enabled by defining XFER_COUNT_EN.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic [2:0] level;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // Credit check: words held plus the one in flight, minus the one leaving now.
  assign level   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd = reset_n & ~fifo_empty & (level < 3'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

`ifdef XFER_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_count <= '0;
    end else if (pop) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end
`else
  assign xfer_count = '0;
`endif

  underflow_check: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_rd && fifo_empty))
    else $error("%s", MSG_UNDERFLOW);

endmodule
